// File: rtl/stream_downsizer.sv
// Width downsizer: accepts one wide beat and emits it as RATIO narrow words, LSB slice first.
// A new beat may load in the same cycle the final slice leaves, so a continuous stream has no bubbles.
module stream_downsizer #(
    parameter int DATA_IN_WIDTH  = 128,
    parameter int DATA_OUT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dataIn_valid,
    output logic                      dataIn_ready,
    input  logic [DATA_IN_WIDTH-1:0]  dataIn_payload,
    input  logic                      dataIn_last,
    output logic                      dataOut_valid,
    input  logic                      dataOut_ready,
    output logic [DATA_OUT_WIDTH-1:0] dataOut_payload,
    output logic                      dataOut_last
);
    localparam int RATIO = (DATA_OUT_WIDTH > 0) ? (DATA_IN_WIDTH / DATA_OUT_WIDTH) : 0;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    generate
        if (DATA_OUT_WIDTH <= 0 || (DATA_IN_WIDTH % DATA_OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
            $error("stream_downsizer: DATA_IN_WIDTH must be an exact multiple (at least 2x) of DATA_OUT_WIDTH");
        end
    endgenerate

    logic [DATA_IN_WIDTH-1:0] buf_q, buf_d;
    logic                     last_q, last_d;
    logic                     full_q, full_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [RATIO-1:0][DATA_OUT_WIDTH-1:0] slices;
    logic on_last_slice;
    logic in_fire;
    logic out_fire;

    assign slices        = buf_q;
    assign on_last_slice = (cnt_q == LAST_CNT);

    // Ready only looks ahead when the slice now on the output is the final one.
    assign dataIn_ready    = !full_q || (dataOut_ready && on_last_slice);
    assign in_fire         = dataIn_valid && dataIn_ready;
    assign out_fire        = full_q && dataOut_ready;

    assign dataOut_valid   = full_q;
    assign dataOut_payload = slices[cnt_q];
    assign dataOut_last    = full_q && last_q && on_last_slice;

    always_comb begin
        buf_d  = buf_q;
        last_d = last_q;
        full_d = full_q;
        cnt_d  = cnt_q;
        if (out_fire) begin
            if (on_last_slice) begin
                full_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_q + 1'b1;
            end
        end
        // A load overrides the drain of the final slice, keeping the stream gap-free.
        if (in_fire) begin
            buf_d  = dataIn_payload;
            last_d = dataIn_last;
            full_d = 1'b1;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q  <= '0;
            last_q <= 1'b0;
            full_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            buf_q  <= buf_d;
            last_q <= last_d;
            full_q <= full_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_stream_downsizer.sv
// Bench for stream_downsizer: a queue of expected narrow words predicts every output cycle,
// with a second 64->16 instance exercising the parameterisation.
`timescale 1ns/1ps
module tb_stream_downsizer;
    localparam int IN_W    = 128;
    localparam int OUT_W   = 32;
    localparam int RATIO   = IN_W / OUT_W;
    localparam int OBS_W   = OUT_W + 3;
    localparam int N_IN_W  = 64;
    localparam int N_OUT_W = 16;
    localparam int N_RATIO = N_IN_W / N_OUT_W;
    localparam int N_OBS_W = N_OUT_W + 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic [IN_W-1:0]   in_payload = '0;
    logic              out_ready = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic              out_last;
    logic [OUT_W-1:0]  out_payload;

    logic              n_valid = 1'b0;
    logic              n_last = 1'b0;
    logic [N_IN_W-1:0] n_payload = '0;
    logic              n_oready = 1'b0;
    logic              n_iready;
    logic              n_ovalid;
    logic              n_olast;
    logic [N_OUT_W-1:0] n_opayload;

    int n_cmp = 0;
    int n_fail = 0;

    // scoreboards: {last, word} in emission order
    logic [OUT_W:0]   exp_q[$];
    logic [N_OUT_W:0] n_exp_q[$];

    stream_downsizer dut (
        .clk(clk), .reset(rst),
        .dataIn_valid(in_valid), .dataIn_ready(in_ready),
        .dataIn_payload(in_payload), .dataIn_last(in_last),
        .dataOut_valid(out_valid), .dataOut_ready(out_ready),
        .dataOut_payload(out_payload), .dataOut_last(out_last)
    );

    stream_downsizer #(.DATA_IN_WIDTH(N_IN_W), .DATA_OUT_WIDTH(N_OUT_W)) dut_n (
        .clk(clk), .reset(rst),
        .dataIn_valid(n_valid), .dataIn_ready(n_iready),
        .dataIn_payload(n_payload), .dataIn_last(n_last),
        .dataOut_valid(n_ovalid), .dataOut_ready(n_oready),
        .dataOut_payload(n_opayload), .dataOut_last(n_olast)
    );

    function automatic logic [IN_W-1:0] rand_wide();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Driver + model step: entered at a negedge with inputs set; samples, predicts, advances the model.
    task automatic wide_cycle(output logic [OBS_W-1:0] obs, output logic [OBS_W-1:0] exp,
                              output logic in_fire);
        logic ev;
        logic er;
        logic [OUT_W:0] front;
        #1;
        ev    = (exp_q.size() != 0);
        front = ev ? exp_q[0] : '0;
        er    = !ev || (out_ready && exp_q.size() == 1);
        exp   = {ev, er, front[OUT_W], front[OUT_W-1:0]};
        obs   = {out_valid, in_ready, out_last, out_valid ? out_payload : OUT_W'(0)};
        in_fire = in_valid && er;
        if (ev && out_ready) void'(exp_q.pop_front());
        if (in_fire)
            for (int i = 0; i < RATIO; i++)
                exp_q.push_back({in_last && (i == RATIO - 1), in_payload[i*OUT_W +: OUT_W]});
        @(negedge clk);
    endtask

    task automatic drain_wide(input string name);
        logic [OBS_W-1:0] obs, exp;
        logic f;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < RATIO + 2; c++) begin
            wide_cycle(obs, exp, f);
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s_drain c%0d: got %h want %h", name, c, obs, exp);
            end
        end
    endtask

    task automatic test_reset;
        #1;
        n_cmp += 5;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", out_last); end
        if (out_payload !== '0) begin n_fail++; $display("FAIL reset_payload: got %h want 0", out_payload); end
        if ({n_ovalid, n_iready, n_olast, n_opayload} !== {3'b010, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_narrow: got %b%b%b %h want 010 0000", n_ovalid, n_iready, n_olast, n_opayload);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_beat;
        logic [OBS_W-1:0] obs, exp;
        logic [OBS_W-1:0] want [6];
        logic f;
        want[0] = {3'b010, 32'h0};
        want[1] = {3'b100, 32'h11111111};
        want[2] = {3'b100, 32'h22222222};
        want[3] = {3'b100, 32'h33333333};
        want[4] = {3'b111, 32'h44444444};
        want[5] = {3'b010, 32'h0};
        in_valid   = 1'b1;
        in_payload = 128'h44444444_33333333_22222222_11111111;
        in_last    = 1'b1;
        out_ready  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            wide_cycle(obs, exp, f);
            if (f) in_valid = 1'b0;
            n_cmp++;
            if (obs !== want[c]) begin
                n_fail++;
                $display("FAIL single_beat c%0d: got %h want %h", c, obs, want[c]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [OBS_W-1:0] obs, exp;
        logic f;
        logic [13:0] rdy_mask, vld_mask;
        int beats;
        beats = 0;
        rdy_mask = '0;
        vld_mask = '0;
        in_valid = 1'b1; in_payload = rand_wide(); in_last = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            wide_cycle(obs, exp, f);
            rdy_mask[c] = obs[OBS_W-2];
            vld_mask[c] = obs[OBS_W-1];
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL back_to_back c%0d: got %h want %h", c, obs, exp);
            end
            if (f) begin
                beats++;
                if (beats == 3) in_valid = 1'b0;
                else begin
                    in_payload = rand_wide();
                    in_last = (beats == 2);
                end
            end
        end
        n_cmp += 2;
        if (rdy_mask !== 14'h3111) begin n_fail++; $display("FAIL b2b_ready_cycles: got %h want 3111", rdy_mask); end
        if (vld_mask !== 14'h1ffe) begin n_fail++; $display("FAIL b2b_valid_cycles: got %h want 1ffe", vld_mask); end
    endtask

    task automatic test_backpressure;
        logic [OBS_W-1:0] obs, exp;
        logic f;
        int c;
        c = 0;
        in_valid = 1'b1; in_last = 1'b1;
        in_payload = 128'h44444444_33333333_22222222_11111111;
        while ((in_valid || exp_q.size() != 0) && c < 80) begin
            out_ready = ($urandom_range(0, 2) == 0);
            wide_cycle(obs, exp, f);
            if (f) in_valid = 1'b0;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL backpressure c%0d: got %h want %h", c, obs, exp);
            end
            c++;
        end
        n_cmp++;
        if (c >= 80) begin n_fail++; $display("FAIL backpressure_timeout: got %0d cycles want < 80", c); end
        drain_wide("backpressure");
    endtask

    task automatic test_blocking;
        logic [OBS_W-1:0] obs, exp;
        logic f;
        logic orq [12];
        int first_rdy;
        orq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        first_rdy = -1;
        in_valid = 1'b1; in_payload = rand_wide(); in_last = 1'b0;
        for (int c = 0; c < 12; c++) begin
            out_ready = orq[c];
            wide_cycle(obs, exp, f);
            if (c > 0 && first_rdy < 0 && obs[OBS_W-2]) first_rdy = c;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL blocking c%0d: got %h want %h", c, obs, exp);
            end
            if (f && c == 0) begin
                in_payload = rand_wide();
                in_last = 1'b1;
            end else if (f) begin
                in_valid = 1'b0;
            end
        end
        n_cmp++;
        if (first_rdy != 6) begin n_fail++; $display("FAIL blocking_accept_cycle: got %0d want 6", first_rdy); end
        drain_wide("blocking");
    endtask

    task automatic test_reset_mid_beat;
        logic [OBS_W-1:0] obs, exp;
        logic f;
        in_valid = 1'b1; in_payload = rand_wide(); in_last = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            wide_cycle(obs, exp, f);
            if (f) in_valid = 1'b0;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_pre c%0d: got %h want %h", c, obs, exp);
            end
        end
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, out_last, out_payload} !== {3'b010, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b%b%b %h want 010 00000000", out_valid, in_ready, out_last, out_payload);
        end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
        in_payload = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        for (int c = 0; c < 6; c++) begin
            wide_cycle(obs, exp, f);
            if (f) in_valid = 1'b0;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_post c%0d: got %h want %h", c, obs, exp);
            end
            if (c == 1) begin
                n_cmp++;
                if (obs[OUT_W-1:0] !== 32'hAAAAAAAA) begin
                    n_fail++;
                    $display("FAIL reset_mid_first_word: got %h want aaaaaaaa", obs[OUT_W-1:0]);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [OBS_W-1:0] obs, exp;
        logic f;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_payload = rand_wide();
                in_last = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            wide_cycle(obs, exp, f);
            if (f) in_valid = 1'b0;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL random c%0d: got %h want %h", c, obs, exp);
            end
        end
        drain_wide("random");
    endtask

    task automatic test_narrow_variant;
        logic [N_OBS_W-1:0] obs, exp;
        logic [N_OUT_W:0] front;
        logic ev, er, f;
        n_valid = 1'b1; n_last = 1'b1; n_payload = 64'h4444_3333_2222_1111;
        for (int c = 0; c < 260; c++) begin
            if (c >= 240) begin
                n_valid = 1'b0;
                n_oready = 1'b1;
            end else begin
                if (!n_valid && $urandom_range(0, 2) != 0) begin
                    n_valid = 1'b1;
                    n_payload = {$urandom(), $urandom()};
                    n_last = 1'($urandom_range(0, 1));
                end
                n_oready = (c < 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
            end
            #1;
            ev    = (n_exp_q.size() != 0);
            front = ev ? n_exp_q[0] : '0;
            er    = !ev || (n_oready && n_exp_q.size() == 1);
            exp   = {ev, er, front[N_OUT_W], front[N_OUT_W-1:0]};
            obs   = {n_ovalid, n_iready, n_olast, n_ovalid ? n_opayload : N_OUT_W'(0)};
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL narrow c%0d: got %h want %h", c, obs, exp);
            end
            f = n_valid && er;
            if (ev && n_oready) void'(n_exp_q.pop_front());
            if (f) begin
                for (int i = 0; i < N_RATIO; i++)
                    n_exp_q.push_back({n_last && (i == N_RATIO - 1), n_payload[i*N_OUT_W +: N_OUT_W]});
            end
            @(negedge clk);
            if (f) n_valid = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset;
        test_single_beat;
        test_back_to_back;
        test_backpressure;
        test_blocking;
        test_reset_mid_beat;
        test_random;
        test_narrow_variant;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/stream_downsizer.md
STREAM_DOWNSIZER -- requirements
Module: stream_downsizer

Interface
REQ-001 SHALL provide parameter DATA_IN_WIDTH, default 128, input payload width in bits.
REQ-002 SHALL provide parameter DATA_OUT_WIDTH, default 32, output payload width in bits.
REQ-003 SHALL derive RATIO = DATA_IN_WIDTH / DATA_OUT_WIDTH; legal only if the division is exact and RATIO >= 2; otherwise elaboration SHALL fail.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 dataIn_valid  input  1  upstream beat valid.
REQ-007 dataIn_ready  output  1  block accepts the upstream beat this cycle.
REQ-008 dataIn_payload  input  DATA_IN_WIDTH  wide beat.
REQ-009 dataIn_last  input  1  wide beat is the final beat of a packet.
REQ-010 dataOut_valid  output  1  narrow word valid.
REQ-011 dataOut_ready  input  1  downstream accepts the narrow word.
REQ-012 dataOut_payload  output  DATA_OUT_WIDTH  narrow word.
REQ-013 dataOut_last  output  1  final narrow word of a packet.

Function
REQ-014 Handshake on both ports: transfer occurs iff valid && ready on the same rising edge; once valid is asserted, valid and payload SHALL be held stable until transfer.
REQ-015 State: wide holding register buf, flag last_r, full flag, slice counter cnt of width clog2(RATIO), range 0..RATIO-1.
REQ-016 dataOut_valid SHALL equal full (registered; no combinational path from dataIn_valid).
REQ-017 dataOut_payload SHALL equal buf[cnt*DATA_OUT_WIDTH +: DATA_OUT_WIDTH]; slice 0 (LSBs) SHALL be emitted first.
REQ-018 dataOut_last SHALL equal full && last_r && (cnt == RATIO-1); it SHALL be 0 on all other slices.
REQ-019 dataIn_ready SHALL equal !full || (dataOut_ready && cnt == RATIO-1); this is the only combinational ready path.
REQ-020 On input transfer: buf <= dataIn_payload, last_r <= dataIn_last, full <= 1, cnt <= 0.
REQ-021 On output transfer with cnt < RATIO-1: cnt <= cnt+1, full stays 1.
REQ-022 On output transfer with cnt == RATIO-1 and no simultaneous input transfer: full <= 0, cnt <= 0.
REQ-023 Simultaneous output transfer of the final slice and input transfer: REQ-020 SHALL take effect (reload, full stays 1); no bubble cycle inserted.
REQ-024 Latency: first slice of an accepted beat SHALL be valid on dataOut the cycle after input transfer when empty.
REQ-025 Throughput: with dataOut_ready held 1 and input always valid, one narrow word per cycle, one wide beat every RATIO cycles.
REQ-026 dataOut_ready deasserted SHALL freeze cnt, buf, last_r, full; no word lost or duplicated.
REQ-027 While full and cnt < RATIO-1, dataIn_ready SHALL be 0 regardless of dataOut_ready.
REQ-028 No data reordering, padding or dropping: each wide beat produces exactly RATIO narrow words.

Reset
REQ-029 While reset is high: full = 0, cnt = 0, last_r = 0, buf = 0; hence dataOut_valid = 0, dataOut_last = 0, dataOut_payload = 0, dataIn_ready = 1.
REQ-030 Reset asserted mid-beat SHALL discard remaining slices; after deassertion first output SHALL be slice 0 of the next accepted beat.
REQ-031 Reset assertion SHALL act immediately (asynchronously); deassertion is synchronous to clk by the integrating design.

Verification
REQ-032 Single beat: defaults, dataIn_payload = 0x44444444_33333333_22222222_11111111, last=1, dataOut_ready=1 -> outputs 0x11111111, 0x22222222, 0x33333333, 0x44444444 on four consecutive cycles starting 1 cycle after accept, dataOut_last=1 only on 0x44444444.
REQ-033 Back-to-back: 3 beats continuously valid, dataOut_ready=1 -> 12 words on 12 consecutive cycles, dataIn_ready high exactly on cycles showing slice 3 (plus initial empty cycle).
REQ-034 Backpressure: dataOut_ready toggling 1,0,0,1,... pseudo-random -> output sequence identical to REQ-032 order, payload stable while valid && !ready.
REQ-035 Blocking: while full with cnt=1, dataIn_valid=1 with new payload -> dataIn_ready=0, buf unchanged, new beat accepted only on final-slice transfer.
REQ-036 Reset mid-beat: assert reset after slice 1 transferred -> dataOut_valid=0 immediately, dataIn_ready=1; next beat 0xDDDD...AAAA yields slice 0 first.
REQ-037 Parameter variant DATA_IN_WIDTH=64, DATA_OUT_WIDTH=16 -> 4 words per beat, LSB first, last on the 4th.
